// File: rtl/sram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of a single-port SRAM wrapper.
// Holds a grant for a whole cycle, caps hold time under contention, round-robin on ties.
module sram_wb_arbiter #(
  parameter int MAX_BEATS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // instruction-fetch master
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_adr_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  // data master
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_adr_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  // SRAM wrapper slave port
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [31:0] s_adr_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  output logic [1:0]  gnt_o
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0] BEAT_MAX  = CW'(MAX_BEATS);
  localparam logic [CW-1:0] BEAT_LAST = CW'(MAX_BEATS - 1);

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic          last_gnt;  // 0: M0 was granted last, 1: M1
  logic [CW-1:0] beat_cnt;
  logic          m0_req, m1_req;

  assign m0_req = m0_cyc_i & m0_stb_i;
  assign m1_req = m1_cyc_i & m1_stb_i;

  // NOTE: sequential state uses non-blocking assignments; the async reset makes the
  // grant (and every slave-side output derived from it) drop without waiting for an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      last_gnt <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt != IDLE) begin
        last_gnt <= (state_nxt == GNT1);
        beat_cnt <= '0;
      end else if (state != IDLE && s_ack_i && beat_cnt != BEAT_MAX) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

  // Forced release only on an ack, so a beat is never split.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_req && (!m1_req || last_gnt)) state_nxt = GNT0;
        else if (m1_req)                     state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i || (s_ack_i && m1_req && beat_cnt >= BEAT_LAST)) state_nxt = IDLE;
      end
      GNT1: begin
        if (!m1_cyc_i || (s_ack_i && m0_req && beat_cnt >= BEAT_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (state)
      GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
      end
      GNT1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the ack qualifies it.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = state;

endmodule

// File: tb/tb_sram_wb_arbiter.sv
// Directed bench for sram_wb_arbiter with a one-cycle delayed-ack SRAM slave model.
// Inputs change and outputs are sampled on the falling edge.
module tb_sram_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        m0_cyc, m0_stb, m0_we;
  logic [31:0] m0_adr, m0_dat_w;
  logic [3:0]  m0_sel;
  logic [31:0] m0_dat_o;
  logic        m0_ack_o;
  logic        m1_cyc, m1_stb, m1_we;
  logic [31:0] m1_adr, m1_dat_w;
  logic [3:0]  m1_sel;
  logic [31:0] m1_dat_o;
  logic        m1_ack_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i;
  logic [1:0]  gnt_o;

  logic slave_ack = 1'b0;
  logic auto_ack  = 1'b1;
  logic man_ack   = 1'b0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Slave model: ack toggles while cyc&stb are held, cleared whenever cyc drops.
  always @(posedge clk) slave_ack <= s_cyc_o & s_stb_o & ~slave_ack;
  assign s_ack_i = auto_ack ? slave_ack : man_ack;
  assign s_dat_i = {16'hDA7A, s_adr_o[15:0]};

  sram_wb_arbiter #(.MAX_BEATS(8)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat_w), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat_w), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
    .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o)
  );

  task automatic idle_masters();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_dat_w = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_dat_w = '0;
  endtask

  task automatic m0_read(input logic [31:0] adr);
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = adr; m0_sel = 4'hF;
  endtask

  task automatic m1_read(input logic [31:0] adr);
    m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = adr; m1_sel = 4'hF;
  endtask

  // Steps falling edges until the chosen master sees an ack; bounded to 10 cycles.
  task automatic wait_ack(input int m, output bit ok);
    ok = 0;
    for (int c = 0; c < 10; c++) begin
      if ((m == 0 && m0_ack_o) || (m == 1 && m1_ack_o)) begin
        ok = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_i = 1;
    idle_masters();
    repeat (2) @(negedge clk);
    checks++; if (gnt_o !== 2'b00) $display("FAIL reset_gnt: got %b want 00", gnt_o); else passed++;
    checks++; if (s_cyc_o !== 1'b0) $display("FAIL reset_cyc: got %b want 0", s_cyc_o); else passed++;
    checks++; if (s_stb_o !== 1'b0) $display("FAIL reset_stb: got %b want 0", s_stb_o); else passed++;
    checks++; if ({m0_ack_o, m1_ack_o} !== 2'b00) $display("FAIL reset_acks: got %b want 00", {m0_ack_o, m1_ack_o}); else passed++;
    checks++; if (m0_dat_o !== 32'hDA7A_0000) $display("FAIL reset_dat: got %h want da7a0000", m0_dat_o); else passed++;
    // A request during reset must not be granted.
    m0_read(32'h10);
    @(negedge clk);
    checks++; if (gnt_o !== 2'b00) $display("FAIL reset_req_gnt: got %b want 00", gnt_o); else passed++;
    checks++; if (s_adr_o !== 32'h0) $display("FAIL reset_req_adr: got %h want 0", s_adr_o); else passed++;
    idle_masters();
    rst_i = 0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int lat = -1, m0a = 0, m1a = 0;
    logic [1:0]  gnt_first = 2'b00, gnt_ack = 2'b00;
    logic [31:0] adr_first = '0, dat = '0;
    m0_read(32'h0000_0010);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin gnt_first = gnt_o; adr_first = s_adr_o; end
      if (m1_ack_o) m1a++;
      if (m0_ack_o) begin
        m0a++; lat = c; dat = m0_dat_o; gnt_ack = gnt_o;
        m0_cyc = 0; m0_stb = 0;
        break;
      end
    end
    checks++; if (gnt_first !== 2'b01) $display("FAIL single_gnt: got %b want 01", gnt_first); else passed++;
    checks++; if (adr_first !== 32'h10) $display("FAIL single_adr: got %h want 10", adr_first); else passed++;
    checks++; if (lat !== 2) $display("FAIL single_latency: got %0d want 2", lat); else passed++;
    checks++; if (m0a !== 1) $display("FAIL single_acks: got %0d want 1", m0a); else passed++;
    checks++; if (dat !== 32'hDA7A_0010) $display("FAIL single_dat: got %h want da7a0010", dat); else passed++;
    checks++; if (gnt_ack !== 2'b01) $display("FAIL single_gnt_at_ack: got %b want 01", gnt_ack); else passed++;
    checks++; if (m1a !== 0) $display("FAIL single_m1_ack: got %0d want 0", m1a); else passed++;
    @(negedge clk);
    checks++; if (gnt_o !== 2'b00) $display("FAIL single_gnt_after: got %b want 00", gnt_o); else passed++;
    checks++; if (m0_ack_o !== 1'b0) $display("FAIL single_ack_after: got %b want 0", m0_ack_o); else passed++;
  endtask

  task automatic test_tie();
    bit ok;
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    m0_read(32'h20);
    m1_read(32'h30);
    @(negedge clk);
    checks++; if (gnt_o !== 2'b01) $display("FAIL tie_first_gnt: got %b want 01", gnt_o); else passed++;
    checks++; if (s_adr_o !== 32'h20) $display("FAIL tie_first_adr: got %h want 20", s_adr_o); else passed++;
    wait_ack(0, ok);
    checks++; if (ok !== 1'b1) $display("FAIL tie_m0_ack: got %b want 1", ok); else passed++;
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    checks++; if ({gnt_o, s_cyc_o} !== 3'b000) $display("FAIL tie_idle: got %b want 000", {gnt_o, s_cyc_o}); else passed++;
    @(negedge clk);
    checks++; if (gnt_o !== 2'b10) $display("FAIL tie_second_gnt: got %b want 10", gnt_o); else passed++;
    checks++; if (s_adr_o !== 32'h30) $display("FAIL tie_second_adr: got %h want 30", s_adr_o); else passed++;
    wait_ack(1, ok);
    checks++; if (ok !== 1'b1) $display("FAIL tie_m1_ack: got %b want 1", ok); else passed++;
    m1_cyc = 0; m1_stb = 0;
    @(negedge clk);
    checks++; if (gnt_o !== 2'b00) $display("FAIL tie_end_gnt: got %b want 00", gnt_o); else passed++;
  endtask

  task automatic test_preempt();
    logic [1:0]  owner [8];
    int          sacks [8];
    int          gap   [8];
    logic [31:0] log_adr [20];
    logic [1:0]  prev = 2'b00;
    int nseg = 0, idle_run = 0, m1b = 0, m0b = 0, leak = 0, seq_err = 0;
    bit done = 0;
    for (int i = 0; i < 8; i++) begin owner[i] = 2'b00; sacks[i] = 0; gap[i] = 0; end
    for (int i = 0; i < 20; i++) log_adr[i] = '0;
    m1_read(32'h200);
    @(negedge clk);
    checks++; if (gnt_o !== 2'b10) $display("FAIL preempt_m1_gnt: got %b want 10", gnt_o); else passed++;
    m0_read(32'h40);
    for (int c = 0; c < 300 && !done; c++) begin
      if (gnt_o == 2'b00) idle_run++;
      else begin
        if (gnt_o != prev) begin
          if (nseg < 8) begin owner[nseg] = gnt_o; gap[nseg] = idle_run; end
          nseg++;
        end
        idle_run = 0;
      end
      prev = gnt_o;
      if (gnt_o == 2'b10 && s_adr_o !== m1_adr) leak++;
      if (gnt_o == 2'b01 && s_adr_o !== m0_adr) leak++;
      if (m1_ack_o) begin
        if (m1b < 20) log_adr[m1b] = s_adr_o;
        m1b++;
        if (nseg >= 1 && nseg <= 8) sacks[nseg-1]++;
        m1_adr = 32'h200 + 32'(4 * m1b);
        if (m1b == 20) begin m1_cyc = 0; m1_stb = 0; end
      end
      if (m0_ack_o) begin
        m0b++;
        if (nseg >= 1 && nseg <= 8) sacks[nseg-1]++;
        m0_adr = m0_adr + 32'h4;
        if (m0b == 2) begin m0_cyc = 0; m0_stb = 0; end
      end
      if (m1b >= 20 && m0b >= 2) done = 1;
      @(negedge clk);
    end
    idle_masters();
    for (int i = 0; i < 20; i++)
      if (log_adr[i] !== 32'h200 + 32'(4 * i)) seq_err++;
    checks++; if (done !== 1'b1) $display("FAIL preempt_done: got m1=%0d m0=%0d want 20/2", m1b, m0b); else passed++;
    checks++; if (nseg !== 3) $display("FAIL preempt_segments: got %0d want 3", nseg); else passed++;
    checks++; if (owner[0] !== 2'b10) $display("FAIL preempt_owner0: got %b want 10", owner[0]); else passed++;
    checks++; if (owner[1] !== 2'b01) $display("FAIL preempt_owner1: got %b want 01", owner[1]); else passed++;
    checks++; if (owner[2] !== 2'b10) $display("FAIL preempt_owner2: got %b want 10", owner[2]); else passed++;
    checks++; if (sacks[0] !== 8) $display("FAIL preempt_m1_first_acks: got %0d want 8", sacks[0]); else passed++;
    checks++; if (sacks[1] !== 2) $display("FAIL preempt_m0_acks: got %0d want 2", sacks[1]); else passed++;
    checks++; if (sacks[2] !== 12) $display("FAIL preempt_m1_rest_acks: got %0d want 12", sacks[2]); else passed++;
    checks++; if (gap[1] !== 1) $display("FAIL preempt_gap1: got %0d want 1", gap[1]); else passed++;
    checks++; if (gap[2] !== 1) $display("FAIL preempt_gap2: got %0d want 1", gap[2]); else passed++;
    checks++; if (seq_err !== 0) $display("FAIL preempt_addr_seq: got %0d errors want 0", seq_err); else passed++;
    checks++; if (leak !== 0) $display("FAIL preempt_mux_leak: got %0d want 0", leak); else passed++;
    checks++; if (gnt_o !== 2'b00) $display("FAIL preempt_end_gnt: got %b want 00", gnt_o); else passed++;
  endtask

  task automatic test_write_sel();
    bit ok;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h100; m1_sel = 4'b0011; m1_dat_w = 32'hCAFE_0100;
    @(negedge clk);
    checks++; if (gnt_o !== 2'b10) $display("FAIL wsel_gnt: got %b want 10", gnt_o); else passed++;
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h80; m0_sel = 4'hF; m0_dat_w = 32'hBAD0_BAD0;
    #1;
    checks++; if (s_sel_o !== 4'b0011) $display("FAIL wsel_sel: got %b want 0011", s_sel_o); else passed++;
    checks++; if (s_adr_o !== 32'h100) $display("FAIL wsel_adr: got %h want 100", s_adr_o); else passed++;
    checks++; if (s_we_o !== 1'b1) $display("FAIL wsel_we: got %b want 1", s_we_o); else passed++;
    checks++; if (s_dat_o !== 32'hCAFE_0100) $display("FAIL wsel_dat: got %h want cafe0100", s_dat_o); else passed++;
    wait_ack(1, ok);
    checks++; if (ok !== 1'b1) $display("FAIL wsel_ack: got %b want 1", ok); else passed++;
    checks++; if ({s_sel_o, m0_ack_o} !== 5'b0011_0) $display("FAIL wsel_at_ack: got %b want 00110", {s_sel_o, m0_ack_o}); else passed++;
    idle_masters();
    repeat (2) @(negedge clk);
    checks++; if (gnt_o !== 2'b00) $display("FAIL wsel_end_gnt: got %b want 00", gnt_o); else passed++;
  endtask

  task automatic test_abort();
    auto_ack = 0;
    man_ack  = 0;
    m0_read(32'h50);
    @(negedge clk);
    checks++; if (gnt_o !== 2'b01) $display("FAIL abort_gnt: got %b want 01", gnt_o); else passed++;
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    checks++; if (gnt_o !== 2'b00) $display("FAIL abort_idle: got %b want 00", gnt_o); else passed++;
    man_ack = 1;
    #1;
    checks++; if ({m0_ack_o, m1_ack_o} !== 2'b00) $display("FAIL abort_late_ack: got %b want 00", {m0_ack_o, m1_ack_o}); else passed++;
    @(negedge clk);
    checks++; if ({gnt_o, m0_ack_o, m1_ack_o} !== 4'b0000) $display("FAIL abort_after: got %b want 0000", {gnt_o, m0_ack_o, m1_ack_o}); else passed++;
    man_ack  = 0;
    auto_ack = 1;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    m0_read(32'h60);
    @(negedge clk);
    checks++; if (gnt_o !== 2'b01) $display("FAIL arst_gnt: got %b want 01", gnt_o); else passed++;
    @(negedge clk);
    checks++; if (m0_ack_o !== 1'b1) $display("FAIL arst_ack_before: got %b want 1", m0_ack_o); else passed++;
    #2 rst_i = 1;
    #1;
    checks++; if (gnt_o !== 2'b00) $display("FAIL arst_gnt_now: got %b want 00", gnt_o); else passed++;
    checks++; if ({s_cyc_o, s_stb_o} !== 2'b00) $display("FAIL arst_cyc_now: got %b want 00", {s_cyc_o, s_stb_o}); else passed++;
    checks++; if ({m0_ack_o, m1_ack_o} !== 2'b00) $display("FAIL arst_ack_now: got %b want 00", {m0_ack_o, m1_ack_o}); else passed++;
    m1_read(32'h70);
    @(negedge clk);
    rst_i = 0;
    @(negedge clk);
    checks++; if (gnt_o !== 2'b01) $display("FAIL arst_tie_gnt: got %b want 01", gnt_o); else passed++;
    checks++; if (s_adr_o !== 32'h60) $display("FAIL arst_tie_adr: got %h want 60", s_adr_o); else passed++;
    idle_masters();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_i = 1;
    idle_masters();
    test_reset();
    test_single_read();
    test_tie();
    test_preempt();
    test_write_sel();
    test_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
